// File: rtl/tone_arb_pkg.sv
// Shared types and constant helpers for the tone arbiter.
// Optional feature macro: TONE_ARB_ROUND_ROBIN_EN (round-robin beep selection).
package tone_arb_pkg;

    localparam int unsigned PERIOD_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_GAP    = 2'd1,
        ST_BEEP   = 2'd2
    } state_t;

    // Where the arbiter goes once the current silent gap expires.
    typedef enum logic {
        TGT_STREAM = 1'b0,
        TGT_BEEP   = 1'b1
    } target_t;

    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_arb_picker.sv
// Combinational beep winner selection from the pending mask.
// TONE_ARB_ROUND_ROBIN_EN selects round-robin after last_grant; otherwise lowest index wins.
module tone_arb_picker
    import tone_arb_pkg::*;
#(
    parameter int unsigned NUM_BEEP = 4,
    parameter int unsigned ID_W     = clog2_f(NUM_BEEP)
) (
    input  logic [NUM_BEEP-1:0] pending,
`ifdef TONE_ARB_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]     last_grant,
`endif
    output logic [ID_W-1:0]     winner_c,
    output logic                any_c
);

    assign any_c = |pending;

`ifdef TONE_ARB_ROUND_ROBIN_EN
    // Scan starting one past the last grant, wrapping, so the last winner is checked last.
    always_comb begin
        logic found;
        int   idx;
        winner_c = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= int'(NUM_BEEP); k++) begin
            idx = (int'(last_grant) + k) % int'(NUM_BEEP);
            if (!found && pending[idx]) begin
                winner_c = ID_W'(idx);
                found    = 1'b1;
            end
        end
    end
`else
    // Descending scan leaves the lowest set index as the winner.
    always_comb begin
        winner_c = '0;
        for (int i = int'(NUM_BEEP) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner_c = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/tone_arbiter.sv
// Shares one tone generator between the music stream and one-shot UI beeps, with silent gaps.
// TONE_ARB_ROUND_ROBIN_EN enables round-robin beep selection (default: lowest index first).
module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF,
    parameter int unsigned NUM_BEEP     = 4,
    parameter int unsigned BEEP_CYCLES  = 3_300_000,
    parameter int unsigned GAP_CYCLES   = 330_000
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic [PERIOD_WIDTH-1:0]          stream_tone,
    input  logic                             stream_valid,
    input  logic [NUM_BEEP-1:0]              beep_req,
    input  logic [NUM_BEEP*PERIOD_WIDTH-1:0] beep_period,
    output logic [PERIOD_WIDTH-1:0]          tone_out,
    output logic                             tone_enable,
    output logic [clog2_f(NUM_BEEP)-1:0]     grant_id,
    output logic                             beep_busy,
    output logic                             beep_drop
);

    localparam int unsigned ID_W  = clog2_f(NUM_BEEP);
    localparam int unsigned CNT_W = clog2_f(max_f(max_f(BEEP_CYCLES, GAP_CYCLES), 2));

    state_t                  state;
    target_t                 next_tgt;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_BEEP-1:0]     pending;
    logic [NUM_BEEP-1:0]     pend_eff;
    logic [NUM_BEEP-1:0]     grant_mask;
    logic [ID_W-1:0]         winner;
    logic                    any;
    logic                    grant;
    logic [PERIOD_WIDTH-1:0] periods [NUM_BEEP];
    logic [PERIOD_WIDTH-1:0] beep_sel;

    for (genvar g = 0; g < NUM_BEEP; g++) begin : g_unpack
        assign periods[g] = beep_period[g*PERIOD_WIDTH +: PERIOD_WIDTH];
    end

    // Live period of the beep currently granted.
    assign beep_sel = periods[grant_id];

    // Same-cycle requests count as pending for both transitions and arbitration.
    assign pend_eff = pending | beep_req;

    assign grant      = (state == ST_GAP) && (cnt == '0) && ((next_tgt == TGT_BEEP) || any);
    assign grant_mask = grant ? (NUM_BEEP'(1) << winner) : '0;

`ifdef TONE_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_grant;

    // Reset to the top index so the first grant favours index 0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant <= ID_W'(NUM_BEEP - 1);
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    tone_arb_picker #(
        .NUM_BEEP (NUM_BEEP),
        .ID_W     (ID_W)
    ) u_picker (
        .pending    (pend_eff),
`ifdef TONE_ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .winner_c   (winner),
        .any_c      (any)
    );

    // State, counter, pending mask and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_STREAM;
            next_tgt    <= TGT_STREAM;
            cnt         <= '0;
            pending     <= '0;
            tone_out    <= '0;
            tone_enable <= 1'b0;
            grant_id    <= '0;
            beep_busy   <= 1'b0;
            beep_drop   <= 1'b0;
        end else begin
            pending     <= pend_eff & ~grant_mask;
            beep_drop   <= |(beep_req & pending);
            tone_out    <= '0;
            tone_enable <= 1'b0;
            beep_busy   <= 1'b0;

            case (state)
                ST_STREAM: begin
                    tone_out    <= stream_valid ? stream_tone : '0;
                    tone_enable <= stream_valid && (stream_tone != '0);
                    if (any) begin
                        state    <= ST_GAP;
                        cnt      <= CNT_W'(GAP_CYCLES - 1);
                        next_tgt <= TGT_BEEP;
                    end
                end

                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (any) begin
                            next_tgt <= TGT_BEEP;
                        end
                    end else if (grant) begin
                        state    <= ST_BEEP;
                        cnt      <= CNT_W'(BEEP_CYCLES - 1);
                        grant_id <= winner;
                    end else begin
                        state <= ST_STREAM;
                    end
                end

                ST_BEEP: begin
                    tone_out    <= beep_sel;
                    tone_enable <= (beep_sel != '0);
                    beep_busy   <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state    <= ST_GAP;
                        cnt      <= CNT_W'(GAP_CYCLES - 1);
                        next_tgt <= any ? TGT_BEEP : TGT_STREAM;
                    end
                end

                default: begin
                    state <= ST_STREAM;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed scoreboard bench for tone_arbiter (NUM_BEEP=4, BEEP_CYCLES=20, GAP_CYCLES=4).
module tb_tone_arbiter;

    localparam int unsigned PW = 24;
    localparam int unsigned NB = 4;
    localparam int unsigned IW = 2;
    localparam logic [PW-1:0] STREAM_T = 24'd75000;

    typedef struct packed {
        logic [PW-1:0] tone;
        logic          en;
        logic          busy;
        logic [IW-1:0] gid;
        logic          drop;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [PW-1:0]    stream_tone;
    logic             stream_valid;
    logic [NB-1:0]    beep_req;
    logic [NB*PW-1:0] beep_period;
    logic [PW-1:0]    tone_out;
    logic             tone_enable;
    logic [IW-1:0]    grant_id;
    logic             beep_busy;
    logic             beep_drop;

    obs_t          exp_q[$];
    string         tag_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] per [NB];

    always #5 clk = ~clk;

    tone_arbiter #(
        .PERIOD_WIDTH (PW),
        .NUM_BEEP     (NB),
        .BEEP_CYCLES  (20),
        .GAP_CYCLES   (4)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .stream_tone  (stream_tone),
        .stream_valid (stream_valid),
        .beep_req     (beep_req),
        .beep_period  (beep_period),
        .tone_out     (tone_out),
        .tone_enable  (tone_enable),
        .grant_id     (grant_id),
        .beep_busy    (beep_busy),
        .beep_drop    (beep_drop)
    );

    function automatic obs_t sample();
        obs_t o;
        o.tone = tone_out;
        o.en   = tone_enable;
        o.busy = beep_busy;
        o.gid  = beep_busy ? grant_id : '0;
        o.drop = beep_drop;
        return o;
    endfunction

    task automatic push_n(input int n, input logic [PW-1:0] t, input logic en, input logic busy,
                          input logic [IW-1:0] gid, input logic drop, input string tag);
        obs_t e;
        e.tone = t;
        e.en   = en;
        e.busy = busy;
        e.gid  = gid;
        e.drop = drop;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic exp_stream(input int n, input string tag);
        push_n(n, STREAM_T, 1'b1, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic exp_gap(input int n, input string tag);
        push_n(n, '0, 1'b0, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic exp_beep(input int id, input int n, input string tag);
        push_n(n, per[id], per[id] != '0, 1'b1, IW'(id), 1'b0, tag);
    endtask

    task automatic compare(input obs_t o, input obs_t e, input string tag);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed tone=%0d en=%0b busy=%0b gid=%0d drop=%0b, expected tone=%0d en=%0b busy=%0b gid=%0d drop=%0b",
                   tag, o.tone, o.en, o.busy, o.gid, o.drop, e.tone, e.en, e.busy, e.gid, e.drop);
        end
    endtask

    // One clock per expected entry; inputs change at the negedge after sampling.
    task automatic run(input int n);
        obs_t  e;
        string t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_underflow: observed empty queue, expected an entry");
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                compare(sample(), e, t);
            end
        end
    endtask

    task automatic drain();
        run(exp_q.size());
    endtask

    task automatic check_gid_zero(input string tag);
        checks++;
        assert (grant_id === '0) else begin
            errors++;
            $error("FAIL %s: observed grant_id=%0d, expected 0", tag, grant_id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_id;
        int second_id;
        obs_t zero;
        zero = '0;

        rst_b        = 1'b0;
        stream_valid = 1'b0;
        stream_tone  = '0;
        beep_req     = '0;
        per[0] = 24'd1000;
        per[1] = 24'd2000;
        per[2] = 24'd18939;
        per[3] = 24'd3000;
        for (int i = 0; i < int'(NB); i++) beep_period[i*PW +: PW] = per[i];

        // Reset state
        exp_gap(2, "reset");
        run(2);
        check_gid_zero("reset_gid");

        // Stream only
        rst_b        = 1'b1;
        stream_valid = 1'b1;
        stream_tone  = STREAM_T;
        exp_stream(3, "stream_on");
        drain();
        stream_tone = '0;
        exp_gap(2, "stream_rest");
        drain();
        stream_valid = 1'b0;
        stream_tone  = STREAM_T;
        exp_gap(2, "stream_invalid");
        drain();
        stream_valid = 1'b1;
        exp_stream(1, "stream_back");
        drain();

        // Single beep on requester 2
        exp_stream(1, "t3_pre");
        exp_gap(4, "t3_gap_in");
        exp_beep(2, 20, "t3_beep");
        exp_gap(4, "t3_gap_out");
        exp_stream(2, "t3_resume");
        beep_req = 4'b0100;
        run(1);
        beep_req = '0;
        drain();

        // Simultaneous requests 1 and 3
`ifdef TONE_ARB_ROUND_ROBIN_EN
        first_id  = 3;
        second_id = 1;
`else
        first_id  = 1;
        second_id = 3;
`endif
        exp_stream(1, "t4a_pre");
        exp_gap(4, "t4a_gap_in");
        exp_beep(first_id, 20, "t4a_beep_first");
        exp_gap(4, "t4a_gap_mid");
        exp_beep(second_id, 20, "t4a_beep_second");
        exp_gap(4, "t4a_gap_out");
        exp_stream(2, "t4a_resume");
        beep_req = 4'b1010;
        run(1);
        beep_req = '0;
        drain();

        // Requests 0 and 1: index 0 first in both selection modes
        exp_stream(1, "t4b_pre");
        exp_gap(4, "t4b_gap_in");
        exp_beep(0, 20, "t4b_beep0");
        exp_gap(4, "t4b_gap_mid");
        exp_beep(1, 20, "t4b_beep1");
        exp_gap(4, "t4b_gap_out");
        exp_stream(2, "t4b_resume");
        beep_req = 4'b0011;
        run(1);
        beep_req = '0;
        drain();

        // Duplicate request while pending
        exp_stream(1, "t5_pre");
        push_n(1, '0, 1'b0, 1'b0, '0, 1'b1, "t5_drop");
        exp_gap(3, "t5_gap_in");
        exp_beep(0, 20, "t5_beep");
        exp_gap(4, "t5_gap_out");
        exp_stream(2, "t5_resume");
        beep_req = 4'b0001;
        run(1);
        beep_req = 4'b0001;
        run(1);
        beep_req = '0;
        drain();

        // Replay: request 1 during its own beep
        exp_stream(1, "t6_pre");
        exp_gap(4, "t6_gap_in");
        exp_beep(1, 20, "t6_beep_a");
        exp_gap(4, "t6_gap_mid");
        exp_beep(1, 20, "t6_beep_b");
        exp_gap(4, "t6_gap_out");
        exp_stream(2, "t6_resume");
        beep_req = 4'b0010;
        run(1);
        beep_req = '0;
        run(10);
        beep_req = 4'b0010;
        run(1);
        beep_req = '0;
        drain();

        // Reset mid-beep with another request pending
        exp_stream(1, "t1_pre");
        exp_gap(4, "t1_gap_in");
        exp_beep(2, 6, "t1_beep");
        beep_req = 4'b0100;
        run(1);
        beep_req = '0;
        run(9);
        beep_req = 4'b1000;
        run(1);
        beep_req = '0;
        rst_b = 1'b0;
        #1;
        compare(sample(), zero, "t1_async_reset");
        check_gid_zero("t1_async_gid");
        exp_gap(1, "t1_held");
        run(1);
        rst_b = 1'b1;
        exp_stream(25, "t1_after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
